sipo_deserializer: RTL and testbench

Parametrised serial-in/parallel-out deserializer, successor to the fixed 4-bit SIPO shift register. It collects a gated serial bit stream into WIDTH-bit words, with selectable bit order. Each completed word goes to a one-entry output buffer with a valid/ready handshake. It sits between a serial receive front end and word-oriented downstream logic, flagging any word lost to back-pressure.

---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_out_buf.sv | 80 ++++++++
 rtl/sipo_deserializer.sv | 71 +++++++
 tb/tb_sipo_deserializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and checks for the serial/parallel converter family
package sipo_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // Output buffer state encoding, shared with the serializer side of the family.
    localparam logic BUF_EMPTY_ENC = 1'b0;
    localparam logic BUF_FULL_ENC  = 1'b1;

    typedef enum logic {
        BUF_EMPTY = BUF_EMPTY_ENC,
        BUF_FULL  = BUF_FULL_ENC
    } buf_state_t;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// rtl/sipo_out_buf.sv - one-entry valid/ready holding register that drops and flags on full
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    buf_state_t state, state_next;
    logic       load;
    logic       drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A word completing in the same cycle the held word is consumed replaces it
    // directly, so a streaming producer sees no bubble.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (q_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_next = BUF_EMPTY;
                    end
                end else if (in_valid) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_next = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    assign q_valid = (state == BUF_FULL);

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - gated serial-in/parallel-out deserializer with buffered word output
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             b_valid,
    input  logic             b,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    input  logic             overrun_clr
);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("sipo_deserializer: WIDTH must lie in 2..64");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             shift;
    logic             word_done;

    if (MSB_FIRST) begin : g_msb_first
        assign sr_next = {sr[WIDTH-2:0], b};
    end else begin : g_lsb_first
        assign sr_next = {b, sr[WIDTH-1:1]};
    end

    // clr outranks a qualified bit, so the bit arriving with clr is discarded.
    assign shift     = b_valid && !clr;
    assign word_done = shift && (bit_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= sr_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // The buffer takes the post-shift value so the final bit lands in the same edge.
    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (word_done),
        .in_data     (sr_next),
        .q           (q),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - randomized and directed bench for sipo_deserializer against a word-level model
module tb_sipo_deserializer;

    localparam int W = 4;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic b_valid = 1'b0;
    logic b = 1'b0;
    logic q_ready = 1'b0;
    logic overrun_clr = 1'b0;

    logic [W-1:0]  qa, qb;
    logic          qva, qvb;
    logic [CW-1:0] cnta, cntb;
    logic          ova, ovb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .b_valid(b_valid), .b(b),
        .q(qa), .q_valid(qva), .q_ready(q_ready), .bit_cnt(cnta),
        .overrun(ova), .overrun_clr(overrun_clr)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .b_valid(b_valid), .b(b),
        .q(qb), .q_valid(qvb), .q_ready(q_ready), .bit_cnt(cntb),
        .overrun(ovb), .overrun_clr(overrun_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits of the current frame in arrival order, plus the buffered words.
    bit         m_bits [W];
    int         m_n;
    bit         m_valid;
    bit [W-1:0] m_qa, m_qb;
    bit         m_ovr;

    function automatic bit [W-1:0] compose(input bit msb_first, input bit lastb);
        bit [W-1:0] w;
        bit         v;
        w = '0;
        for (int i = 0; i < W; i++) begin
            v = (i == W - 1) ? lastb : m_bits[i];
            if (msb_first) w = (w << 1) | W'(v);
            else           w = w | (W'(v) << i);
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     <= 0;
            m_valid <= 1'b0;
            m_qa    <= '0;
            m_qb    <= '0;
            m_ovr   <= 1'b0;
        end else begin
            automatic bit         done = 1'b0;
            automatic bit [W-1:0] wa = '0;
            automatic bit [W-1:0] wb = '0;
            if (clr) begin
                m_n <= 0;
            end else if (b_valid) begin
                if (m_n == W - 1) begin
                    done = 1'b1;
                    wa   = compose(1'b1, b);
                    wb   = compose(1'b0, b);
                    m_n  <= 0;
                end else begin
                    m_bits[m_n] <= b;
                    m_n         <= m_n + 1;
                end
            end
            if (done && (!m_valid || q_ready)) begin
                m_valid <= 1'b1;
                m_qa    <= wa;
                m_qb    <= wb;
            end else if (m_valid && q_ready) begin
                m_valid <= 1'b0;
            end
            if (done && m_valid && !q_ready) m_ovr <= 1'b1;
            else if (overrun_clr)            m_ovr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("msb_q", qa, m_qa);
        check("lsb_q", qb, m_qb);
        check("msb_q_valid", qva, m_valid);
        check("lsb_q_valid", qvb, m_valid);
        check("msb_bit_cnt", cnta, m_n);
        check("lsb_bit_cnt", cntb, m_n);
        check("msb_overrun", ova, m_ovr);
        check("lsb_overrun", ovb, m_ovr);
    end

    task automatic send(input logic bv, input logic bit_in);
        b_valid = bv;
        b       = bit_in;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_qa"}, qa, 0);
        check({tag, "_qb"}, qb, 0);
        check({tag, "_qva"}, qva, 0);
        check({tag, "_qvb"}, qvb, 0);
        check({tag, "_cnta"}, cnta, 0);
        check({tag, "_ova"}, ova, 0);
    endtask

    initial begin
        logic [3:0] pat;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Consecutive bits 1,0,1,0 with the consumer ready.
        q_ready = 1'b1;
        pat = 4'b1010;
        for (int i = 3; i >= 0; i--) send(1'b1, pat[i]);
        check("dir_msb_word", qa, 4'b1010);
        check("dir_lsb_word", qb, 4'b0101);
        check("dir_q_valid", qva, 1);
        check("dir_bit_cnt", cnta, 0);
        @(negedge clk);
        check("dir_one_cycle_valid", qva, 0);

        // Same word with three idle cycles between bits.
        for (int i = 3; i >= 0; i--) begin
            send(1'b1, pat[i]);
            if (i == 2) begin
                repeat (3) @(negedge clk);
                check("gap_cnt_held", cnta, 2);
            end else if (i != 0) begin
                repeat (3) @(negedge clk);
            end
        end
        check("gap_msb_word", qa, 4'b1010);
        check("gap_lsb_word", qb, 4'b0101);
        @(negedge clk);

        // Two frames while stalled: second is dropped and flagged.
        q_ready = 1'b0;
        repeat (4) send(1'b1, 1'b1);
        repeat (4) send(1'b1, 1'b0);
        check("ovr_q_kept", qa, 4'b1111);
        check("ovr_flag", ova, 1);
        q_ready = 1'b1;
        @(negedge clk);
        q_ready = 1'b0;
        check("ovr_drain", qva, 0);
        check("ovr_sticky", ova, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_cleared", ova, 0);

        // Consume exactly when the next word completes.
        pat = 4'b1100;
        for (int i = 3; i >= 0; i--) send(1'b1, pat[i]);
        check("b2b_first", qa, 4'b1100);
        pat = 4'b0011;
        for (int i = 3; i >= 1; i--) send(1'b1, pat[i]);
        check("b2b_hold", qva, 1);
        q_ready = 1'b1;
        send(1'b1, pat[0]);
        q_ready = 1'b0;
        check("b2b_msb_word", qa, 4'b0011);
        check("b2b_lsb_word", qb, 4'b1100);
        check("b2b_no_bubble", qva, 1);
        check("b2b_no_overrun", ova, 0);
        q_ready = 1'b1;
        @(negedge clk);

        // clr after two bits, then a full frame.
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_cnt", cnta, 0);
        pat = 4'b0110;
        for (int i = 3; i >= 0; i--) send(1'b1, pat[i]);
        check("clr_msb_word", qa, 4'b0110);
        check("clr_lsb_word", qb, 4'b0110);

        // clr together with a qualified bit discards the bit.
        send(1'b1, 1'b1);
        clr = 1'b1;
        send(1'b1, 1'b1);
        clr = 1'b0;
        check("clr_wins", cnta, 0);

        // Asynchronous reset in the middle of a frame, away from any clock edge.
        q_ready = 1'b0;
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) send(1'b1, pat[i]);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            b_valid     = ($urandom % 4) != 0;
            b           = $urandom % 2;
            q_ready     = ($urandom % 3) == 0;
            clr         = ($urandom % 40) == 0;
            overrun_clr = ($urandom % 25) == 0;
            @(negedge clk);
        end
        b_valid = 1'b0;
        clr = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
